// File: rtl/tx_driver_pkg.sv
// Shared types for the UART string driver: FSM state encoding and the default
// terminator character.
package tx_driver_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_WAIT_EMPTY,
    S_GO,
    S_GAP_CNT,
    S_DONE
  } tx_state_e;

  localparam logic [7:0] TERM_DEFAULT = 8'h00;

endpackage

// File: rtl/tx_msg_rom.sv
// Message store: DEPTH x DATA_W array with a registered read port. Contents are
// normally preloaded into mem from a hex image and are never touched by reset.
module tx_msg_rom #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The write port allows in-system message updates; the driver ties it off.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tx_string_driver.sv
// Walks a message slot of the ROM and hands each character to a UART
// transmitter with a one-cycle XMitGo strobe, pacing characters by GAP cycles.
import tx_driver_pkg::*;

module tx_string_driver #(
  parameter int                DATA_W  = 8,
  parameter int                DEPTH   = 64,
  parameter int                NUM_MSG = 4,
  parameter int                GAP     = 50,
  parameter logic [DATA_W-1:0] TERM    = DATA_W'(TERM_DEFAULT),
  localparam int               MSG_W   = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
  input  logic              Enable,
  input  logic              Reset,
  input  logic              Start,
  input  logic [MSG_W-1:0]  MsgSel,
  input  logic              Repeat,
  input  logic              TxEmpty,
  output logic              XMitGo,
  output logic [DATA_W-1:0] TxData,
  output logic              Busy,
  output logic              Done
);

  localparam int SLOT = DEPTH / NUM_MSG;
  localparam int AW   = $clog2(DEPTH);
  // GAP=0 would give a zero-width counter; keep one bit that is never used.
  localparam int GW   = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [AW-1:0] SLOT_LAST = AW'(SLOT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);

  tx_state_e         state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     base_q, base_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              xmit_q, xmit_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] txdata_q, txdata_d;
  logic [DATA_W-1:0] rom_data;
  logic              rom_rd_en;
  logic              advance;

  assign rom_rd_en = (state_q == S_FETCH);

  tx_msg_rom #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rom (
    .clk     (Enable),
    .rd_en   (rom_rd_en),
    .rd_addr (addr_q),
    .rd_data (rom_data),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_data ('0)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    gap_d    = gap_q;
    txdata_d = txdata_q;
    xmit_d   = 1'b0;
    done_d   = 1'b0;
    advance  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          base_d  = AW'(MsgSel) * AW'(SLOT);
          addr_d  = base_d;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (rom_data == TERM) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          txdata_d = rom_data;
          state_d  = S_WAIT_EMPTY;
        end
      end
      S_WAIT_EMPTY: begin
        if (TxEmpty) begin
          state_d = S_GO;
          xmit_d  = 1'b1;
        end
      end
      S_GO: begin
        if (GAP == 0) begin
          advance = 1'b1;
        end else begin
          gap_d   = '0;
          state_d = S_GAP_CNT;
        end
      end
      S_GAP_CNT: begin
        if (gap_q == GAP_LAST) advance = 1'b1;
        else gap_d = gap_q + 1'b1;
      end
      S_DONE: begin
        if (Repeat) begin
          addr_d  = base_q;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A slot with no terminator ends at its last entry, never spilling over.
    if (advance) begin
      if (addr_q == base_q + SLOT_LAST) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge Enable) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      gap_q    <= '0;
      xmit_q   <= 1'b0;
      done_q   <= 1'b0;
      txdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      gap_q    <= gap_d;
      xmit_q   <= xmit_d;
      done_q   <= done_d;
      txdata_q <= txdata_d;
    end
  end

  assign XMitGo = xmit_q;
  assign Done   = done_q;
  assign TxData = txdata_q;
  assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_string_driver.sv
// Directed bench: a queue of expected characters (-1 marks Done) is filled from
// the bench's own copy of the ROM image and drained as the DUT strobes.
module tb_tx_string_driver;

  localparam int SLOT = 16;

  logic       Enable = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] MsgSel;
  logic       Repeat;
  logic       TxEmpty;
  logic       XMitGo;
  logic [7:0] TxData;
  logic       Busy;
  logic       Done;

  logic       tx_block;
  logic [7:0] img [64];
  int         exp_q[$];
  int         pulse_cyc[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         dones = 0;
  int         done_cyc = 0;
  int         max_rd = -1;
  int         mon_e;

  tx_string_driver #(
    .DATA_W (8), .DEPTH (64), .NUM_MSG (4), .GAP (4), .TERM (8'h00)
  ) DUT (
    .Enable  (Enable),
    .Reset   (Reset),
    .Start   (Start),
    .MsgSel  (MsgSel),
    .Repeat  (Repeat),
    .TxEmpty (TxEmpty),
    .XMitGo  (XMitGo),
    .TxData  (TxData),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Enable = ~Enable;
  assign TxEmpty = tx_block ? 1'b0 : !XMitGo;

  initial forever begin
    @(posedge Enable);
    cyc++;
  end

  // Output monitor: every strobe and every Done must match the queue head.
  initial forever begin
    @(negedge Enable);
    if (DUT.u_rom.rd_en && int'(DUT.u_rom.rd_addr) > max_rd) max_rd = int'(DUT.u_rom.rd_addr);
    if (XMitGo || Done) begin
      checks++;
      mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : -2;
      if (Done) begin
        dones++;
        done_cyc = cyc;
        assert (mon_e === -1) else begin
          failures++;
          $error("FAIL done_event observed=Done expected=%0d", mon_e);
        end
      end else begin
        pulses++;
        pulse_cyc.push_back(cyc);
        assert (int'(TxData) === mon_e) else begin
          failures++;
          $error("FAIL tx_char observed=%0h expected=%0h", TxData, mon_e);
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Enable);
    #1;
  endtask

  task automatic push_msg(input int sel);
    for (int i = 0; i < SLOT; i++) begin
      if (img[sel*SLOT + i] == 8'h00) break;
      exp_q.push_back(int'(img[sel*SLOT + i]));
    end
    exp_q.push_back(-1);
  endtask

  task automatic start_msg(input int sel, input logic rep);
    @(negedge Enable);
    Start = 1'b1; MsgSel = 2'(sel); Repeat = rep;
    @(negedge Enable);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick(1);
      if (!Busy) break;
    end
    chk(tag, int'(Busy), 0);
  endtask

  task automatic wait_pulses(input string tag, input int n, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick(1);
      if (pulses >= n) break;
    end
    chk(tag, pulses, n);
  endtask

  task automatic clear_stats();
    pulses = 0; dones = 0; pulse_cyc.delete();
  endtask

  int c0, rel;

  initial begin
    Reset = 1'b1; Start = 1'b0; MsgSel = 2'd0; Repeat = 1'b0; tx_block = 1'b0;
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    img[0] = "H"; img[1] = "I";
    for (int i = 0; i < SLOT; i++) img[16 + i] = 8'h61 + 8'(i);
    img[33] = "Z";
    img[48] = "A"; img[49] = "B";
    for (int i = 0; i < 64; i++) DUT.u_rom.mem[i] <= img[i];
    tick(3);
    chk("reset_xmitgo", int'(XMitGo), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_txdata", int'(TxData), 0);
    Reset = 1'b0;
    tick(2);

    // "HI" at GAP=4: two strobes eight cycles apart, one Done
    clear_stats(); push_msg(0); start_msg(0, 1'b0);
    wait_idle("hi_idle", 200);
    chk("hi_pulses", pulses, 2);
    chk("hi_spacing", (pulse_cyc.size() == 2) ? pulse_cyc[1] - pulse_cyc[0] : -1, 8);
    chk("hi_dones", dones, 1);
    chk("hi_queue", exp_q.size(), 0);

    // full 16-byte slot, MsgSel changed while busy
    clear_stats(); max_rd = -1; push_msg(1); start_msg(1, 1'b0);
    MsgSel = 2'd2;
    wait_idle("full_idle", 400);
    chk("full_pulses", pulses, 16);
    chk("full_max_rd", max_rd, 31);
    chk("full_queue", exp_q.size(), 0);

    // terminator as first byte
    clear_stats(); push_msg(2);
    @(negedge Enable); c0 = cyc;
    Start = 1'b1; MsgSel = 2'd2; Repeat = 1'b0;
    @(negedge Enable); Start = 1'b0;
    wait_idle("empty_idle", 50);
    chk("empty_latency_ok", int'(done_cyc - c0 >= 1 && done_cyc - c0 <= 3), 1);
    chk("empty_pulses", pulses, 0);
    chk("empty_dones", dones, 1);

    // repeat, dropped during the second 'A'
    clear_stats(); push_msg(3); push_msg(3); start_msg(3, 1'b1);
    wait_pulses("rep_second_a", 3, 200);
    Repeat = 1'b0;
    wait_idle("rep_idle", 200);
    chk("rep_pulses", pulses, 4);
    chk("rep_dones", dones, 2);
    chk("rep_queue", exp_q.size(), 0);

    // transmitter stalled for 30 cycles
    clear_stats(); push_msg(0); tx_block = 1'b1; start_msg(0, 1'b0);
    tick(33);
    chk("stall_no_pulse", pulses, 0);
    chk("stall_busy", int'(Busy), 1);
    tx_block = 1'b0; rel = cyc;
    wait_idle("stall_idle", 200);
    chk("stall_release_lat", (pulse_cyc.size() > 0) ? pulse_cyc[0] - rel : -1, 1);
    chk("stall_pulses", pulses, 2);
    chk("stall_queue", exp_q.size(), 0);

    // reset in the gap after the second character, then a clean replay
    clear_stats(); push_msg(0); start_msg(0, 1'b0);
    wait_pulses("rst_second", 2, 200);
    tick(1);
    Reset = 1'b1;
    tick(1);
    chk("rst_xmitgo", int'(XMitGo), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_txdata", int'(TxData), 0);
    Reset = 1'b0;
    exp_q.delete(); clear_stats();
    push_msg(0); start_msg(0, 1'b0);
    wait_idle("rst_replay_idle", 200);
    chk("rst_replay_pulses", pulses, 2);
    chk("rst_replay_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_string_driver.md
TX_STRING_DRIVER -- requirements
Module: tx_string_driver

Interface
REQ-001 The block SHALL expose parameter DATA_W, 8, character width in bits.
REQ-002 The block SHALL expose parameter DEPTH, 64, total ROM entries; a power of two and a multiple of NUM_MSG.
REQ-003 The block SHALL expose parameter NUM_MSG, 4, number of message slots; each slot is SLOT = DEPTH/NUM_MSG entries, slot k based at k*SLOT.
REQ-004 The block SHALL expose parameter GAP, 50, idle clock cycles inserted after each XMitGo pulse; 0 is legal.
REQ-005 The block SHALL expose parameter TERM, 8'h00, terminator character value.
REQ-006 Enable  input  1  sole clock, rising edge; one clock, reset synchronous active-high.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 Start  input  1  request to send a message; sampled only in IDLE.
REQ-009 MsgSel  input  $clog2(NUM_MSG)  message slot index, captured with Start.
REQ-010 Repeat  input  1  1 = replay the message continuously; sampled at end of each message.
REQ-011 TxEmpty  input  1  UART transmitter ready for a new character (level).
REQ-012 XMitGo  output  1  one-cycle load strobe to the transmitter.
REQ-013 TxData  output  DATA_W  character for the transmitter, stable from the XMitGo cycle until the next fetch.
REQ-014 Busy  output  1  high in every state except IDLE.
REQ-015 Done  output  1  one-cycle pulse when a message pass completes.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, CHECK, WAIT_EMPTY, GO, GAP_CNT, DONE.
REQ-017 IDLE with Start=1 SHALL latch base = MsgSel*SLOT and addr = base, then move to FETCH; Start outside IDLE SHALL be ignored.
REQ-018 FETCH SHALL issue a synchronous ROM read at addr; data SHALL be available in CHECK one cycle later.
REQ-019 CHECK SHALL go to DONE if the read character equals TERM, else load TxData and go to WAIT_EMPTY.
REQ-020 WAIT_EMPTY SHALL hold until TxEmpty=1, then go to GO; there SHALL be no timeout.
REQ-021 GO SHALL assert XMitGo for exactly one cycle, then go to GAP_CNT, or directly to the advance step when GAP=0.
REQ-022 GAP_CNT SHALL count GAP cycles using a counter of width $clog2(GAP+1), then advance.
REQ-023 Advance SHALL go to DONE if addr = base+SLOT-1 (slot end without terminator), else increment addr and go to FETCH; addr SHALL never cross into the next slot.
REQ-024 DONE SHALL assert Done for one cycle; if Repeat=1, addr SHALL reload to base and the FSM SHALL go to FETCH, else to IDLE.
REQ-025 If the first character of a slot is TERM, the FSM SHALL produce Done with zero XMitGo pulses.
REQ-026 Changes to MsgSel during Busy SHALL have no effect; deasserting Repeat mid-message SHALL finish the current pass and then go to IDLE.
REQ-027 Minimum per-character period, with TxEmpty held high, SHALL be 4+GAP cycles (FETCH, CHECK, WAIT_EMPTY, GO, then GAP).

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE, XMitGo=0, Done=0, Busy=0, TxData=0, addr=0, and gap counter=0, overriding any state including mid-GO.
REQ-029 ROM contents SHALL NOT be affected by Reset.

Structure
REQ-030 Package tx_driver_pkg SHALL hold the state enum type and the default TERM constant.
REQ-031 The ROM SHALL be sub-module tx_msg_rom, instance u_rom, array named mem of DEPTH x DATA_W, synchronous read, preloadable by $readmemh via DUT.u_rom.mem.
REQ-032 The implementation SHALL have no latches, and all outputs SHALL be registered except Busy, which SHALL be decoded from state.

Verification
REQ-033 The bench SHALL cover: slot 0 = "HI",00; GAP=4; Start with MsgSel=0; TxEmpty=!XMitGo -> exactly 2 XMitGo pulses with TxData 'H' then 'I', spaced 8 cycles apart, then one Done, then IDLE.
REQ-034 The bench SHALL cover: slot 1 holds 16 non-TERM bytes (SLOT=16) -> 16 pulses, Done after the pulse for addr 31, and no read of addr 32.
REQ-035 The bench SHALL cover: slot 2 first byte 00 -> Done within 3 cycles of Start, with no XMitGo.
REQ-036 The bench SHALL cover: Repeat=1 on "AB",00 -> sequence A,B,Done,A,B,...; dropping Repeat during the second 'A' -> ends after 'B' with Done, then IDLE.
REQ-037 The bench SHALL cover: TxEmpty held 0 for 30 cycles in WAIT_EMPTY -> no XMitGo; pulse occurs 1 cycle after TxEmpty rises.
REQ-038 The bench SHALL cover: Reset pulsed during GAP_CNT of the 2nd character -> next cycle IDLE with all outputs 0; a new Start replays from the 1st character.
